// File: rtl/quan_pkg.sv
// Shared definitions for the quantisation bias-add stage: mode encodings, channel count, lane layout.
package quan_pkg;

    localparam logic [1:0] QMODE_1CH = 2'd0;
    localparam logic [1:0] QMODE_2CH = 2'd1;
    localparam logic [1:0] QMODE_4CH = 2'd2;

    // Returns 0 for an encoding this build cannot serve, which callers treat as a mode error.
    function automatic int unsigned qmode_n_ch(input logic [1:0] mode, input int ch_max);
        case (mode)
            QMODE_1CH: return 1;
            QMODE_2CH: return 2;
            QMODE_4CH: return (ch_max == 4) ? 4 : 0;
            default:   return 0;
        endcase
    endfunction

    function automatic int qlane_lsb(input int ch, input int lane, input int lanes_ch, input int p_width);
        return (ch * lanes_ch + lane) * p_width;
    endfunction

endpackage

// File: rtl/quan_lane_sat.sv
// Clamps one two's-complement lane to OUT_WIDTH signed range, sign-extended back to P_WIDTH.
// Purely combinational; o_clamped flags that the input was out of range.
module quan_lane_sat #(
    parameter int P_WIDTH   = 40,
    parameter int OUT_WIDTH = 16
) (
    input  logic [P_WIDTH-1:0] i_lane,
    output logic [P_WIDTH-1:0] o_lane,
    output logic               o_clamped
);

    // The value fits when every bit from the OUT_WIDTH sign bit upward agrees.
    logic [P_WIDTH-OUT_WIDTH:0] w_top;
    logic                       w_fits;

    assign w_top     = i_lane[P_WIDTH-1:OUT_WIDTH-1];
    assign w_fits    = (&w_top) || !(|w_top);
    assign o_clamped = !w_fits;

    always_comb begin
        o_lane = i_lane;
        if (!w_fits) begin
            if (i_lane[P_WIDTH-1])
                o_lane = {{(P_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
            else
                o_lane = {{(P_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/quan_product_add_bias_vec_pipe.sv
// Per-channel bias add on the sum x E vector with double-buffered bias; QUAN_BIAS_SAT_EN adds a clamp stage.
// Latency 1 (2 with QUAN_BIAS_SAT_EN); global stall, in_ready = !out_valid | out_ready.
module quan_product_add_bias_vec_pipe
    import quan_pkg::*;
#(
    parameter int COLUMN_NUM = 16,
    parameter int PIXEL_PAR  = 2,
    parameter int CH_MAX     = 4,
    parameter int P_WIDTH    = 40,
    parameter int BIAS_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [1:0]                                  mode,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        in_first,
    input  logic [CH_MAX*PIXEL_PAR*COLUMN_NUM*P_WIDTH-1:0] sum_vec,
    input  logic                                        bias_load,
    input  logic [CH_MAX*BIAS_WIDTH-1:0]                bias_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [CH_MAX*PIXEL_PAR*COLUMN_NUM*P_WIDTH-1:0] out_vec,
    output logic                                        mode_err,
    output logic [15:0]                                 sat_count
);

    localparam int LANES_CH = PIXEL_PAR * COLUMN_NUM;
    localparam int LANES    = CH_MAX * LANES_CH;
    localparam int VEC_W    = LANES * P_WIDTH;

    logic [CH_MAX*BIAS_WIDTH-1:0] r_shadow;
    logic [CH_MAX*BIAS_WIDTH-1:0] r_active;
    logic [CH_MAX*BIAS_WIDTH-1:0] w_bias;
    logic                         r_mode_err;
    logic                         r_s1_vld;
    logic [VEC_W-1:0]             r_s1_vec;
    logic [VEC_W-1:0]             w_sum;
    logic                         w_accept;
    int unsigned                  w_n_ch;
    logic [CH_MAX-1:0]            w_ch_en;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    // A promoting beat must see the shadow value, not the still-old active register.
    assign w_bias   = (w_accept && in_first) ? r_shadow : r_active;
    assign w_n_ch   = qmode_n_ch(mode, CH_MAX);
    assign mode_err = r_mode_err;

    always_comb begin
        w_ch_en = '0;
        for (int unsigned c = 0; c < CH_MAX; c++)
            w_ch_en[c] = (c < w_n_ch);
    end

    for (genvar gc = 0; gc < CH_MAX; gc++) begin : g_ch
        logic [P_WIDTH-1:0] w_bias_ext;
        assign w_bias_ext = {{(P_WIDTH-BIAS_WIDTH){w_bias[gc*BIAS_WIDTH+BIAS_WIDTH-1]}},
                             w_bias[gc*BIAS_WIDTH +: BIAS_WIDTH]};
        for (genvar gj = 0; gj < LANES_CH; gj++) begin : g_lane
            localparam int LSB = qlane_lsb(gc, gj, LANES_CH, P_WIDTH);
            assign w_sum[LSB +: P_WIDTH] = w_ch_en[gc] ? (sum_vec[LSB +: P_WIDTH] + w_bias_ext) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_mode_err <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_vec   <= '0;
        end else begin
            if (bias_load)
                r_shadow <= bias_in;
            if (w_accept && in_first)
                r_active <= r_shadow;
            if (w_accept && (w_n_ch == 0))
                r_mode_err <= 1'b1;
            if (in_ready)
                r_s1_vld <= in_valid;
            if (w_accept)
                r_s1_vec <= w_sum;
        end
    end

`ifdef QUAN_BIAS_SAT_EN
    localparam int CNT_W = $clog2(LANES + 1);

    logic [VEC_W-1:0] w_clamp_vec;
    logic [LANES-1:0] w_clamped;
    logic [CNT_W-1:0] w_n_clamped;
    logic             r_s2_vld;
    logic [VEC_W-1:0] r_s2_vec;
    logic [CNT_W-1:0] r_s2_ncl;
    logic [15:0]      r_sat_count;
    logic [16:0]      w_sat_sum;

    for (genvar gl = 0; gl < LANES; gl++) begin : g_sat
        quan_lane_sat #(
            .P_WIDTH   (P_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_sat (
            .i_lane    (r_s1_vec[gl*P_WIDTH +: P_WIDTH]),
            .o_lane    (w_clamp_vec[gl*P_WIDTH +: P_WIDTH]),
            .o_clamped (w_clamped[gl])
        );
    end

    always_comb begin
        w_n_clamped = '0;
        for (int l = 0; l < LANES; l++)
            w_n_clamped = w_n_clamped + CNT_W'(w_clamped[l]);
    end

    // The clamp count travels with its beat so it is only credited once the beat is delivered.
    assign w_sat_sum = {1'b0, r_sat_count} + 17'(r_s2_ncl);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld    <= 1'b0;
            r_s2_vec    <= '0;
            r_s2_ncl    <= '0;
            r_sat_count <= '0;
        end else begin
            if (in_ready)
                r_s2_vld <= r_s1_vld;
            if (in_ready && r_s1_vld) begin
                r_s2_vec <= w_clamp_vec;
                r_s2_ncl <= w_n_clamped;
            end
            if (out_valid && out_ready)
                r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    assign out_valid = r_s2_vld;
    assign out_vec   = r_s2_vec;
    assign sat_count = r_sat_count;
`else
    assign out_valid = r_s1_vld;
    assign out_vec   = r_s1_vec;
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_quan_product_add_bias_vec_pipe.sv
// Bench for quan_product_add_bias_vec_pipe: vector table plus hand sequences, scoreboard on the output handshake.
module tb_quan_product_add_bias_vec_pipe;

    localparam int COLUMN_NUM = 16;
    localparam int PIXEL_PAR  = 2;
    localparam int CH_MAX     = 4;
    localparam int P_WIDTH    = 40;
    localparam int BIAS_WIDTH = 8;
    localparam int OUT_WIDTH  = 16;
    localparam int LANES_CH   = PIXEL_PAR * COLUMN_NUM;
    localparam int LANES      = CH_MAX * LANES_CH;
    localparam int VEC_W      = LANES * P_WIDTH;
`ifdef QUAN_BIAS_SAT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef logic signed [P_WIDTH-1:0] lane_t;
    typedef lane_t quad_t [CH_MAX];
    typedef logic [VEC_W-1:0] vec_t;
    typedef struct {
        logic [1:0]  mode;
        logic        first;
        logic        pre_load;
        logic [31:0] bias;
        quad_t       din;
        quad_t       dexp;
    } rec_t;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [1:0]                    mode;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_first;
    logic [VEC_W-1:0]              sum_vec;
    logic                          bias_load;
    logic [CH_MAX*BIAS_WIDTH-1:0]  bias_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [VEC_W-1:0]              out_vec;
    logic                          mode_err;
    logic [15:0]                   sat_count;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t sb_q[$];
    rec_t tbl[$];
    vec_t cap;
    quad_t q_in, q_exp;

    always #5 clk = ~clk;

    quan_product_add_bias_vec_pipe #(
        .COLUMN_NUM (COLUMN_NUM),
        .PIXEL_PAR  (PIXEL_PAR),
        .CH_MAX     (CH_MAX),
        .P_WIDTH    (P_WIDTH),
        .BIAS_WIDTH (BIAS_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .sum_vec   (sum_vec),
        .bias_load (bias_load),
        .bias_in   (bias_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .mode_err  (mode_err),
        .sat_count (sat_count)
    );

    function automatic lane_t clamp(input lane_t v);
`ifdef QUAN_BIAS_SAT_EN
        lane_t hi;
        lane_t lo;
        hi = (lane_t'(1) <<< (OUT_WIDTH-1)) - lane_t'(1);
        lo = -hi - lane_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
`endif
        return v;
    endfunction

    // Lane j of channel c = base[c] (+ j when ramped); channels >= n_act are zero.
    function automatic vec_t mk_vec(input quad_t base, input bit ramp, input int n_act, input bit do_clamp);
        vec_t  v;
        lane_t x;
        v = '0;
        for (int c = 0; c < CH_MAX; c++)
            for (int j = 0; j < LANES_CH; j++) begin
                x = (c < n_act) ? base[c] + (ramp ? lane_t'(j) : lane_t'(0)) : lane_t'(0);
                if (do_clamp) x = clamp(x);
                v[(c*LANES_CH+j)*P_WIDTH +: P_WIDTH] = x;
            end
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_beat: out_valid with nothing expected");
            end else begin
                e = sb_q.pop_front();
                if (out_vec !== e) begin
                    n_errors++;
                    for (int l = 0; l < LANES; l++)
                        if (out_vec[l*P_WIDTH +: P_WIDTH] !== e[l*P_WIDTH +: P_WIDTH]) begin
                            $display("FAIL out_vec lane %0d: got %0h expected %0h", l,
                                     out_vec[l*P_WIDTH +: P_WIDTH], e[l*P_WIDTH +: P_WIDTH]);
                            break;
                        end
                end
            end
        end
    end

    task automatic add_rec(input logic [1:0] m, input bit f, input bit pl, input logic [31:0] b,
                           input lane_t d0, input lane_t d1, input lane_t d2, input lane_t d3,
                           input lane_t e0, input lane_t e1, input lane_t e2, input lane_t e3);
        rec_t r;
        r.mode = m; r.first = f; r.pre_load = pl; r.bias = b;
        r.din[0] = d0; r.din[1] = d1; r.din[2] = d2; r.din[3] = d3;
        r.dexp[0] = e0; r.dexp[1] = e1; r.dexp[2] = e2; r.dexp[3] = e3;
        tbl.push_back(r);
    endtask

    task automatic pre_load(input logic [31:0] b);
        bias_in   = b;
        bias_load = 1'b1;
        @(posedge clk); #1;
        bias_load = 1'b0;
    endtask

    // Offers one beat and returns just after the edge that accepted it.
    task automatic send_beat(input logic [1:0] m, input bit f, input vec_t din, input vec_t dexp,
                             input bit ld, input logic [31:0] b);
        bit ok;
        ok        = 0;
        mode      = m;
        in_first  = f;
        sum_vec   = din;
        bias_load = ld;
        bias_in   = b;
        in_valid  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(dexp);
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready stayed low");
        end else begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        bias_load = 1'b0;
        in_first  = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        bias_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mode = '0; in_valid = 0; in_first = 0; sum_vec = '0;
        bias_load = 0; bias_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_vec", |out_vec, 0);
        chk("reset_mode_err", mode_err, 0);
        chk("reset_sat_count", sat_count, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        add_rec(0, 1, 1, 32'h00000005, 100, 100, 100, 100, 105, 0, 0, 0);
        add_rec(2, 1, 1, 32'h807F01FF, 0, 0, 0, 0, -1, 1, 127, -128);
        add_rec(1, 0, 0, 32'h0, 10, 20, 30, 40, 9, 21, 0, 0);
        add_rec(3, 1, 0, 32'h0, 7, 7, 7, 7, 0, 0, 0, 0);
        add_rec(0, 1, 1, 32'h00000080, -5, -5, -5, -5, -133, 0, 0, 0);
        add_rec(0, 1, 1, 32'h00000001, 40'sh7F_FFFF_FFFF, 1, 1, 1, 40'sh80_0000_0000, 0, 0, 0);
        add_rec(1, 1, 1, 32'h0000F60A, -10, 10, 5, 5, 0, 0, 0, 0);
        add_rec(2, 0, 0, 32'h0, 1, 2, 3, 4, 11, -8, 3, 4);

        foreach (tbl[i]) begin
            if (tbl[i].pre_load) pre_load(tbl[i].bias);
            send_beat(tbl[i].mode, tbl[i].first, mk_vec(tbl[i].din, 0, CH_MAX, 0),
                      mk_vec(tbl[i].dexp, 0, CH_MAX, 1), 0, '0);
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                chk($sformatf("latency_vec%0d_cyc%0d", i, k), out_valid, 64'(k == LAT));
            end
            drain();
        end

        // Bias promotion, including a load that coincides with a promoting accept.
        for (int c = 0; c < CH_MAX; c++) q_in[c] = 0;
        pre_load(32'h03030303);
        q_exp = '{3, 0, 0, 0};
        send_beat(0, 1, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 0, '0);
        send_beat(0, 0, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 1, 32'h09090909);
        q_exp = '{9, 0, 0, 0};
        send_beat(0, 1, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 0, '0);
        send_beat(0, 1, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 1, 32'h0B0B0B0B);
        q_exp = '{11, 0, 0, 0};
        send_beat(0, 1, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 0, '0);
        drain();

        // Backpressure: active bias is now 11 on every channel.
        out_ready = 1'b0;
        fork
            begin
                quad_t bi, be;
                for (int b = 0; b < 8; b++) begin
                    bi = '{lane_t'(b*10), lane_t'(b*10+1000), 7, 7};
                    be = '{lane_t'(b*10+11), lane_t'(b*10+1011), 0, 0};
                    send_beat(1, 0, mk_vec(bi, 1, 4, 0), mk_vec(be, 1, 2, 1), 0, '0);
                end
            end
            begin
                repeat (3) @(negedge clk);
                cap = out_vec;
                for (int k = 0; k < 5; k++) begin
                    chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
                    chk($sformatf("bp_out_valid_%0d", k), out_valid, 1);
                    chk($sformatf("bp_out_vec_stable_%0d", k), 64'(out_vec === cap), 1);
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Unsupported mode and mid-stream reset.
        do_reset();
        @(negedge clk);
        chk("mode_err_cleared", mode_err, 0);
        @(posedge clk); #1;
        send_beat(3, 1, mk_vec(q_in, 0, 4, 0), '0, 0, '0);
        @(negedge clk);
        chk("mode_err_set", mode_err, 1);
        @(posedge clk); #1;
        q_in = '{4, 4, 4, 4};
        q_exp = '{4, 0, 0, 0};
        send_beat(0, 0, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 0, '0);
        send_beat(1, 0, mk_vec(q_in, 0, 4, 0), mk_vec(q_in, 0, 2, 1), 0, '0);
        drain();
        chk("mode_err_sticky", mode_err, 1);

        out_ready = 1'b0;
        send_beat(0, 1, mk_vec(q_in, 0, 4, 0), mk_vec(q_exp, 0, 1, 1), 0, '0);
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_vec", |out_vec, 0);
        chk("midreset_mode_err", mode_err, 0);
        chk("midreset_in_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_emit", out_valid, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;

`ifdef QUAN_BIAS_SAT_EN
        do_reset();
        cap = '0;
        cap[0 +: P_WIDTH]       = lane_t'(40000);
        cap[P_WIDTH +: P_WIDTH] = lane_t'(-40000);
        begin
            vec_t e2;
            e2 = '0;
            e2[0 +: P_WIDTH]       = lane_t'(32767);
            e2[P_WIDTH +: P_WIDTH] = lane_t'(-32768);
            send_beat(0, 1, cap, e2, 0, '0);
        end
        drain();
        chk("sat_count_2", sat_count, 2);
        q_in = '{40000, 40000, 40000, 40000};
        send_beat(2, 0, mk_vec(q_in, 1, 4, 0), mk_vec(q_in, 1, 4, 1), 0, '0);
        drain();
        chk("sat_count_130", sat_count, 130);
        for (int b = 0; b < 510; b++)
            send_beat(2, 0, mk_vec(q_in, 1, 4, 0), mk_vec(q_in, 1, 4, 1), 0, '0);
        drain();
        chk("sat_count_65410", sat_count, 65410);
        send_beat(2, 0, mk_vec(q_in, 1, 4, 0), mk_vec(q_in, 1, 4, 1), 0, '0);
        drain();
        chk("sat_count_sticks", sat_count, 16'hFFFF);
        send_beat(2, 0, mk_vec(q_in, 1, 4, 0), mk_vec(q_in, 1, 4, 1), 0, '0);
        drain();
        chk("sat_count_held", sat_count, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quan_product_add_bias_vec_pipe.md
# quan_product_add_bias_vec_pipe

Parametrised successor to the quantisation bias-add stage: adds a per-channel signed bias to every lane of the scaled-sum vector (sum × E) coming out of the conv core. It supports 1, 2 or 4 output channels per beat and double-buffers the bias. A valid/ready pipeline with backpressure replaces the free-running enable, and optional saturation narrows results to the activation width. It sits between the per-channel E-multiplier and the requant/activation stage.

## Interface
- COLUMN_NUM, 16, SA columns feeding the vector
- PIXEL_PAR, 2, pixels per column per channel
- CH_MAX, 4, max channels per beat (2 or 4)
- P_WIDTH, 40, lane width of sum × E and of the result
- BIAS_WIDTH, 8, signed bias width
- OUT_WIDTH, 16, signed saturation width (used only with QUAN_BIAS_SAT_EN)
- Derived: LANES_CH = PIXEL_PAR·COLUMN_NUM; LANES = CH_MAX·LANES_CH
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mode  in  2  0 = 1 ch, 1 = 2 ch, 2 = 4 ch (only valid when CH_MAX = 4); sampled per beat
- in_valid / in_ready  in / out  1  input handshake
- in_first  in  1  first beat of an output tile; promotes shadow bias
- sum_vec  in  LANES·P_WIDTH  lane j of channel c at bit offset (c·LANES_CH + j)·P_WIDTH
- bias_load  in  1  writes bias_in into the shadow register
- bias_in  in  CH_MAX·BIAS_WIDTH  channel c bias at [c·BIAS_WIDTH +: BIAS_WIDTH]
- out_valid / out_ready  out / in  1  output handshake
- out_vec  out  LANES·P_WIDTH  same layout as sum_vec
- mode_err  out  1  sticky; set by an accepted beat with an unsupported mode
- sat_count  out  16  saturating count of clamped lanes

## Operation
- Shadow bias: bias_load = 1 → shadow ← bias_in.
- Active bias: on an accepted beat (in_valid & in_ready) with in_first = 1 → active ← shadow. That beat uses the promoted value.
- A bias_load in the same cycle as an in_first accept: the beat uses the *old* shadow; the new value lands in shadow only.
- Per lane of active channel c: r = sum_vec lane + sign_ext(active[c]), P_WIDTH two's-complement, wrap on overflow.
- Active channels: mode 0 → c = 0; mode 1 → c < 2; mode 2 → c < 4. Lanes of inactive channels output 0.
- Unsupported mode (3, or 2 with CH_MAX = 2):
  - beat still flows through the pipeline, with all lanes 0;
  - mode_err ← 1, held until reset.
- Reset mid-stream: all stages are dropped and no partial beat is emitted. Values after reset:
  - out_valid = 0, out_vec = 0
  - shadow = active = 0
  - mode_err = 0, sat_count = 0
  - in_ready = 1 in the first cycle after reset deasserts.

## Timing
- Pipeline stages: 1 (macro off) or 2 (macro on). Each stage has its own valid bit.
- Global-stall rule: in_ready = !out_valid | out_ready. All stages advance together when in_ready = 1.
- Latency from accept to out_valid: 1 cycle (macro off) or 2 cycles (macro on).
- Throughput: 1 beat/cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, out_vec is held stable.
- in_ready is combinational from out_valid and out_ready only, never from in_valid.
- mode_err updates the cycle after the offending accept.
- bias_load takes effect for beats accepted from the next cycle onward.

## Configuration
- QUAN_BIAS_SAT_EN defined:
  - adds stage 2, which clamps each active lane to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1];
  - the clamped value is sign-extended back to P_WIDTH;
  - sat_count increments by the number of clamped lanes in each beat delivered on the output handshake, sticking at 0xFFFF.
- QUAN_BIAS_SAT_EN undefined:
  - single stage, no clamping;
  - sat_count tied to 0.

## Structure
- Shared package quan_pkg:
  - mode encodings (QMODE_1CH/2CH/4CH);
  - active-channel-count function mode → n_ch;
  - lane-index helper for the layout above.
- One sub-module, quan_lane_sat: a single lane's clamp plus a "clamped" flag, generated LANES times under the macro.

## Test plan
- Bias 0x05 loaded into ch0; mode 0, in_first = 1, lane value 100 → out lanes of ch0 = 105, other lanes 0; out_valid exactly 1 cycle after accept (2 with macro).
- Mode 2, bias {ch3 = 0x80, ch2 = 0x7F, ch1 = 0x01, ch0 = 0xFF}, all lanes 0 → channel outputs −128, 127, 1, −1 sign-extended to 40 bits.
- Bias promotion:
  - beat A: in_first with shadow = 3;
  - bias_load 9 in the same cycle as the accept of beat B, which has in_first = 0;
  - beat C: in_first = 1;
  - required: A and B use 3; C uses 9.
- Backpressure:
  - out_ready low for 5 cycles with a continuous in_valid stream → in_ready low, out_vec stable;
  - release → no beat lost or duplicated, order preserved.
- Mode 3 beat → all lanes 0, mode_err = 1 next cycle and still 1 after later valid beats; reset mid-stream → out_valid = 0, mode_err = 0 on the next cycle.
- Macro on, OUT_WIDTH 16, lanes 40000 and −40000, bias 0 → 32767 and −32768; sat_count += 2 per delivered beat; saturates at 65535.
